// File: rtl/pad_sensor_conditioner_pkg.sv
// Shared types and constants for the pad sensor front-end.
// Optional build macro: HIT_TIMESTAMP_EN adds a push-time stamp to each hit entry.
package pad_sensor_conditioner_pkg;

    localparam int unsigned PAD_IDX_W               = 5;
    localparam int unsigned SENSOR_BUS_W            = 32;
    localparam int unsigned TS_W                    = 16;
    localparam int unsigned HIT_COUNT_W             = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

    // One queued press event.
    typedef struct packed {
`ifdef HIT_TIMESTAMP_EN
        logic [TS_W-1:0]      ts;
`endif
        logic [PAD_IDX_W-1:0] pad;
    } hit_entry_t;

endpackage

// File: rtl/pad_debouncer.sv
// Two-flop synchronizer plus stable-count debouncer for a single pad bit.
module pad_debouncer
    import pad_sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o,
    output logic rise_o
);

    localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        deb_q, deb_d;
    logic [15:0] cnt_q, cnt_d;

    // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES cycles.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Synchronizer, counter and debounced level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o  = deb_q;
    // Rise is flagged on the same edge that deb goes high.
    assign rise_o = deb_d & ~deb_q;

endmodule

// File: rtl/pad_sensor_conditioner.sv
// Pad sensor front-end: per-pad debounce, press detection, pending-press arbiter and
// show-ahead hit FIFO. Optional build macro: HIT_TIMESTAMP_EN (adds hit_time output).
module pad_sensor_conditioner
    import pad_sensor_conditioner_pkg::*;
#(
    parameter int unsigned NUM_PADS        = 24,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SENSOR_BUS_W-1:0] sensor_raw,
    output logic [SENSOR_BUS_W-1:0] pad_state,
    output logic                    hit_valid,
    output logic [PAD_IDX_W-1:0]    hit_pad,
    input  logic                    hit_pop,
    output logic [HIT_COUNT_W-1:0]  hit_count,
    output logic                    overflow,
    input  logic                    clear_overflow
`ifdef HIT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]         hit_time
`endif
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [NUM_PADS-1:0]  deb, rise, pend_q, pend_d, grant, push_mask;
    logic [PAD_IDX_W-1:0] grant_idx;
    logic                 found, pop_en, push_en, full;
    logic                 overflow_q, overflow_d, valid_q;
    logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    hit_entry_t           mem_q [FIFO_DEPTH];
    hit_entry_t           new_entry;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        pad_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_pad_debouncer (
            .clk_i (clock),
            .rst_i (reset),
            .raw_i (sensor_raw[i]),
            .deb_o (deb[i]),
            .rise_o(rise[i])
        );
    end

    if (NUM_PADS < SENSOR_BUS_W) begin : g_unused
        logic unused_raw;
        assign unused_raw = ^sensor_raw[SENSOR_BUS_W-1:NUM_PADS];
    end

`ifdef HIT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle counter used to stamp pushes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 16'd1;
    end
`endif

    // Lowest-index pending press wins the single push slot.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_PADS; i++) begin
            if (pend_q[i] && !found) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PAD_IDX_W'(i);
            end
        end
    end

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign pop_en    = hit_pop && (count_q != '0);
    assign push_en   = found && (!full || pop_en);
    assign push_mask = push_en ? grant : '0;

    // Pending set, overflow flag and occupancy next-state.
    always_comb begin
        new_entry     = '0;
        new_entry.pad = grant_idx;
`ifdef HIT_TIMESTAMP_EN
        new_entry.ts  = ts_q;
`endif
        pend_d = (pend_q & ~push_mask) | rise;
        // A second press landing on a still-queued pend bit is merged and lost.
        overflow_d = (overflow_q & ~clear_overflow) | (|(rise & pend_q & ~push_mask));
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= new_entry;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q    <= count_d;
            valid_q    <= (count_d != '0);
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    // Debounced levels, unused bus bits held low.
    always_comb begin
        pad_state                = '0;
        pad_state[NUM_PADS-1:0]  = deb;
    end

    assign hit_valid = valid_q;
    assign hit_pad   = mem_q[rd_ptr_q].pad;
    assign hit_count = HIT_COUNT_W'(count_q);
    assign overflow  = overflow_q;
`ifdef HIT_TIMESTAMP_EN
    assign hit_time  = mem_q[rd_ptr_q].ts;
`endif

endmodule

// File: tb/tb_pad_sensor_conditioner.sv
// Directed bench for pad_sensor_conditioner with DEBOUNCE_CYCLES=4.
module tb_pad_sensor_conditioner;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] sensor_raw;
    logic [31:0] pad_state;
    logic        hit_valid;
    logic [4:0]  hit_pad;
    logic        hit_pop;
    logic [3:0]  hit_count;
    logic        overflow;
    logic        clear_overflow;
`ifdef HIT_TIMESTAMP_EN
    logic [15:0] hit_time;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int drain_exp [9];

    pad_sensor_conditioner #(
        .NUM_PADS       (24),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sensor_raw    (sensor_raw),
        .pad_state     (pad_state),
        .hit_valid     (hit_valid),
        .hit_pad       (hit_pad),
        .hit_pop       (hit_pop),
        .hit_count     (hit_count),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
`ifdef HIT_TIMESTAMP_EN
        ,
        .hit_time      (hit_time)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pop_once();
        hit_pop = 1'b1;
        tick(1);
        hit_pop = 1'b0;
    endtask

    initial begin
        drain_exp      = '{1, 2, 3, 4, 5, 6, 7, 8, 1};
        reset          = 1'b1;
        sensor_raw     = '0;
        hit_pop        = 1'b0;
        clear_overflow = 1'b0;
        tick(2);
        check_eq("rst_pad_state", pad_state, 32'h0);
        check_eq("rst_hit_valid", {31'b0, hit_valid}, 32'h0);
        check_eq("rst_hit_count", {28'b0, hit_count}, 32'h0);
        check_eq("rst_overflow", {31'b0, overflow}, 32'h0);
        reset = 1'b0;
        tick(1);

        // Single press on pad 3.
        sensor_raw[3] = 1'b1;
        tick(5);
        check_eq("p3_state_early", pad_state, 32'h0);
        tick(1);
        check_eq("p3_state", pad_state, 32'h8);
        check_eq("p3_valid_early", {31'b0, hit_valid}, 32'h0);
        tick(1);
        check_eq("p3_valid", {31'b0, hit_valid}, 32'h1);
        check_eq("p3_pad", {27'b0, hit_pad}, 32'd3);
        check_eq("p3_count", {28'b0, hit_count}, 32'd1);
        pop_once();
        check_eq("p3_count_popped", {28'b0, hit_count}, 32'd0);
        check_eq("p3_valid_popped", {31'b0, hit_valid}, 32'h0);
        sensor_raw[3] = 1'b0;
        tick(10);
        check_eq("p3_release_count", {28'b0, hit_count}, 32'd0);

        // Pad 5 glitch of 3 cycles.
        sensor_raw[5] = 1'b1;
        tick(3);
        sensor_raw[5] = 1'b0;
        tick(10);
        check_eq("glitch_state", pad_state, 32'h0);
        check_eq("glitch_valid", {31'b0, hit_valid}, 32'h0);
        check_eq("glitch_count", {28'b0, hit_count}, 32'd0);

        // Pads 10, 2, 7 together.
        sensor_raw = 32'h0000_0484;
        tick(7);
        check_eq("multi_count1", {28'b0, hit_count}, 32'd1);
        check_eq("multi_head", {27'b0, hit_pad}, 32'd2);
        tick(1);
        check_eq("multi_count2", {28'b0, hit_count}, 32'd2);
        tick(1);
        check_eq("multi_count3", {28'b0, hit_count}, 32'd3);
        check_eq("multi_pop0", {27'b0, hit_pad}, 32'd2);
        pop_once();
        check_eq("multi_pop1", {27'b0, hit_pad}, 32'd7);
        pop_once();
        check_eq("multi_pop2", {27'b0, hit_pad}, 32'd10);
        pop_once();
        check_eq("multi_empty", {28'b0, hit_count}, 32'd0);
        sensor_raw = '0;
        tick(10);

        // Pads 0..8: fill the FIFO, pad 8 waits in pend.
        sensor_raw = 32'h0000_01ff;
        tick(16);
        check_eq("fill_count", {28'b0, hit_count}, 32'd8);
        check_eq("fill_head", {27'b0, hit_pad}, 32'd0);
        check_eq("fill_overflow", {31'b0, overflow}, 32'h0);
        pop_once();
        check_eq("fill_count_after_pop", {28'b0, hit_count}, 32'd8);
        check_eq("fill_head_after_pop", {27'b0, hit_pad}, 32'd1);

        // Pad 1 re-pressed twice while the FIFO is full.
        sensor_raw[1] = 1'b0;
        tick(8);
        sensor_raw[1] = 1'b1;
        tick(8);
        check_eq("ovf_pend_only", {31'b0, overflow}, 32'h0);
        check_eq("ovf_full_count", {28'b0, hit_count}, 32'd8);
        sensor_raw[1] = 1'b0;
        tick(8);
        sensor_raw[1] = 1'b1;
        tick(8);
        check_eq("ovf_set", {31'b0, overflow}, 32'h1);
        tick(5);
        check_eq("ovf_sticky", {31'b0, overflow}, 32'h1);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("drain_%0d", i), {27'b0, hit_pad}, 32'(drain_exp[i]));
            pop_once();
        end
        check_eq("drain_count", {28'b0, hit_count}, 32'd0);
        check_eq("drain_valid", {31'b0, hit_valid}, 32'h0);
        check_eq("ovf_before_clear", {31'b0, overflow}, 32'h1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        check_eq("ovf_cleared", {31'b0, overflow}, 32'h0);
        sensor_raw = '0;
        tick(10);

        // Reset with 4 queued entries and pad 6 mid-debounce.
        sensor_raw = 32'h0000_000f;
        tick(12);
        check_eq("pre_rst_count", {28'b0, hit_count}, 32'd4);
        sensor_raw[6] = 1'b1;
        tick(3);
        reset = 1'b1;
        sensor_raw[3:0] = 4'h0;
        #1;
        check_eq("async_rst_state", pad_state, 32'h0);
        check_eq("async_rst_valid", {31'b0, hit_valid}, 32'h0);
        check_eq("async_rst_count", {28'b0, hit_count}, 32'd0);
        check_eq("async_rst_pad", {27'b0, hit_pad}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(6);
        check_eq("p6_valid_early", {31'b0, hit_valid}, 32'h0);
        check_eq("p6_state", pad_state, 32'h40);
        tick(1);
        check_eq("p6_valid", {31'b0, hit_valid}, 32'h1);
        check_eq("p6_pad", {27'b0, hit_pad}, 32'd6);
        tick(10);
        check_eq("p6_single", {28'b0, hit_count}, 32'd1);
        pop_once();
        check_eq("p6_empty", {28'b0, hit_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
